// File: rtl/hififo_pcie_pkg.sv
// PCIe TLP constants and header types shared by the hififo request engines.
package hififo_pcie_pkg;

    localparam int unsigned FMT_W  = 3;
    localparam int unsigned TYPE_W = 5;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned RID_W  = 16;
    localparam int unsigned BE_W   = 4;

    localparam logic [FMT_W-1:0]  FMT_MRD32 = 3'b000;
    localparam logic [FMT_W-1:0]  FMT_MRD64 = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_MRD  = 5'b00000;
    localparam logic [BE_W-1:0]   BE_FULL   = 4'hF;

    typedef struct packed {
        logic [63:0] word0;
        logic [63:0] word1;
        logic        wide;
    } mrd_hdr_t;

    // Header DW0 of a memory read: fmt/type, zeroed attribute fields, length in DWs.
    function automatic logic [31:0] mrd_dw0(input logic wide, input logic [LEN_W-1:0] length);
        return {(wide ? FMT_MRD64 : FMT_MRD32), TYPE_MRD, 8'b0, 6'b0, length};
    endfunction

endpackage

// File: rtl/hififo_desc_read_requester_if.sv
// Fetcher, TX request stream and completion stream signals of the descriptor read requester.
interface hififo_desc_read_requester_if
    import hififo_pcie_pkg::*;
#(
    parameter int unsigned AMSB = 63,
    parameter int unsigned DMSB = 63
);

    logic             rr_valid;
    logic [AMSB:0]    rr_addr;
    logic             rr_ready;

    logic [63:0]      tlp_data;
    logic             tlp_valid;
    logic             tlp_upper_valid;
    logic             tlp_last;
    logic             tlp_ready;

    logic [DMSB:0]    cpl_data;
    logic             cpl_valid;
    logic [TAG_W-1:0] cpl_tag;

    logic [DMSB:0]    wdata;
    logic             wvalid;
    logic             rc_last;
    logic             timeout;
    logic             busy;

    modport master (
        input  rr_valid, rr_addr, tlp_ready, cpl_data, cpl_valid, cpl_tag,
        output rr_ready, tlp_data, tlp_valid, tlp_upper_valid, tlp_last,
               wdata, wvalid, rc_last, timeout, busy
    );

    modport slave (
        output rr_valid, rr_addr, tlp_ready, cpl_data, cpl_valid, cpl_tag,
        input  rr_ready, tlp_data, tlp_valid, tlp_upper_valid, tlp_last,
               wdata, wvalid, rc_last, timeout, busy
    );

endinterface

// File: rtl/hififo_tlp_mrd_header.sv
// Combinational builder of the two 64-bit words of a PCIe Memory Read request.
module hififo_tlp_mrd_header
    import hififo_pcie_pkg::*;
#(
    parameter int unsigned AMSB = 63
) (
    input  logic [AMSB:0]      addr,
    input  logic [LEN_W-1:0]   length,
    input  logic [TAG_W-1:0]   tag,
    input  logic [RID_W-1:0]   requester_id,
    output mrd_hdr_t           hdr_c
);

    logic [31:0] addr_hi;
    logic        wide;

    assign addr_hi = 32'(addr[AMSB:32]);
    assign wide    = (addr_hi != 32'd0);

    // A 4DW header is only used when the address does not fit in 32 bits.
    assign hdr_c.wide  = wide;
    assign hdr_c.word0 = {requester_id, tag, BE_FULL, BE_FULL, mrd_dw0(wide, length)};
    assign hdr_c.word1 = wide ? {addr[31:0], addr_hi} : {32'd0, addr[31:0]};

endmodule

// File: rtl/hififo_desc_read_requester.sv
// Issues one descriptor-block memory read at a time and returns its completion
// words to the fetcher, abandoning the read after a long silence.
module hififo_desc_read_requester
    import hififo_pcie_pkg::*;
#(
    parameter int unsigned     AMSB      = 63,
    parameter int unsigned     DMSB      = 63,
    parameter int unsigned     REQ_BYTES = 512,
    parameter logic [TAG_W-1:0] TAG      = 8'd0,
    parameter int unsigned     TIMEOUT   = 1048576
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [RID_W-1:0]    requester_id,
    hififo_desc_read_requester_if.master bus
);

    localparam int unsigned      DATA_W = DMSB + 1;
    localparam int unsigned      WORDS  = REQ_BYTES / 8;
    localparam int unsigned      CNT_W  = $clog2(WORDS) + 1;
    localparam int unsigned      TMR_W  = $clog2(TIMEOUT) + 1;
    localparam logic [LEN_W-1:0] LENGTH = LEN_W'(REQ_BYTES / 4);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, WAIT_CPL} state_t;

    state_t            state;
    logic [AMSB:0]     addr_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [TMR_W-1:0]  timer;
    logic              word_acc;
    mrd_hdr_t          hdr_c;

    hififo_tlp_mrd_header #(.AMSB(AMSB)) u_hdr (
        .addr         (addr_q),
        .length       (LENGTH),
        .tag          (TAG),
        .requester_id (requester_id),
        .hdr_c        (hdr_c)
    );

    assign word_acc     = (state == WAIT_CPL) && bus.cpl_valid && (bus.cpl_tag == TAG);
    assign bus.rr_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    // TX words depend only on state and the latched address, so they hold under backpressure.
    always_comb begin
        bus.tlp_valid       = 1'b0;
        bus.tlp_upper_valid = 1'b0;
        bus.tlp_last        = 1'b0;
        bus.tlp_data        = '0;
        case (state)
            HDR0: begin
                bus.tlp_valid       = 1'b1;
                bus.tlp_upper_valid = 1'b1;
                bus.tlp_data        = hdr_c.word0;
            end
            HDR1: begin
                bus.tlp_valid       = 1'b1;
                bus.tlp_last        = 1'b1;
                bus.tlp_upper_valid = hdr_c.wide;
                bus.tlp_data        = hdr_c.word1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            word_cnt    <= '0;
            timer       <= '0;
            bus.wdata   <= '0;
            bus.wvalid  <= 1'b0;
            bus.rc_last <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.wvalid  <= 1'b0;
            bus.rc_last <= 1'b0;
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rr_valid) begin
                        addr_q <= bus.rr_addr;
                        state  <= HDR0;
                    end
                end
                HDR0: begin
                    if (bus.tlp_ready) state <= HDR1;
                end
                HDR1: begin
                    if (bus.tlp_ready) begin
                        state    <= WAIT_CPL;
                        word_cnt <= '0;
                        timer    <= '0;
                    end
                end
                WAIT_CPL: begin
                    // An accepted word always beats an expiring timer.
                    if (word_acc) begin
                        bus.wvalid <= 1'b1;
                        bus.wdata  <= DATA_W'(bus.cpl_data);
                        word_cnt   <= word_cnt + CNT_W'(1);
                        timer      <= '0;
                        if (word_cnt == CNT_W'(WORDS - 1)) begin
                            bus.rc_last <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        bus.rc_last <= 1'b1;
                        bus.timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hififo_desc_read_requester.sv
// Directed bench for the descriptor read requester: headers, backpressure,
// split completions, tag filtering, timeout and reset abandonment.
module tb_hififo_desc_read_requester;

    logic        clock;
    logic        reset;
    logic [15:0] requester_id;

    hififo_desc_read_requester_if #(.AMSB(63), .DMSB(63)) bus ();

    hififo_desc_read_requester #(
        .AMSB(63), .DMSB(63), .REQ_BYTES(512), .TAG(8'd0), .TIMEOUT(100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .requester_id (requester_id),
        .bus          (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] got_q[$];
    int          n_rc    = 0;
    int          n_rc_wv = 0;
    int          n_to    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Records DUT output events a little after each active edge.
    always @(posedge clock) begin
        #2;
        if (bus.wvalid) got_q.push_back(bus.wdata);
        if (bus.rc_last) begin
            n_rc++;
            if (bus.wvalid) n_rc_wv++;
        end
        if (bus.timeout) n_to++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        got_q.delete();
        n_rc = 0; n_rc_wv = 0; n_to = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rr_valid = 1'b0; bus.rr_addr = '0; bus.tlp_ready = 1'b1;
        bus.cpl_valid = 1'b0; bus.cpl_tag = 8'd0; bus.cpl_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clear_mon();
    endtask

    // Leaves the DUT in HDR0 at a falling edge.
    task automatic issue_request(input logic [63:0] addr);
        bus.rr_valid = 1'b1;
        bus.rr_addr  = addr;
        @(negedge clock);
        bus.rr_valid = 1'b0;
    endtask

    // From HDR0 with tlp_ready high, two accepts bring the DUT to WAIT.
    task automatic pass_header();
        bus.tlp_ready = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_words(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            bus.cpl_valid = 1'b1;
            bus.cpl_tag   = 8'd0;
            bus.cpl_data  = base + 64'(i);
            @(negedge clock);
        end
        bus.cpl_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rr_valid = 1'b0; bus.rr_addr = '0; bus.tlp_ready = 1'b0;
        bus.cpl_valid = 1'b0; bus.cpl_tag = 8'd0; bus.cpl_data = '0;
        requester_id = 16'h0100;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bus.tlp_valid, bus.wvalid, bus.rc_last, bus.timeout, bus.busy} !== 5'b0)
            $display("FAIL reset_outputs got %b required 00000",
                     {bus.tlp_valid, bus.wvalid, bus.rc_last, bus.timeout, bus.busy});
        else n_pass++;
        n_checks++;
        if (bus.rr_ready !== 1'b1) $display("FAIL reset_rr_ready got %b required 1", bus.rr_ready);
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        clear_mon();
    endtask

    task automatic test_hdr64();
        logic [63:0] base = 64'h6400_0000_0000_0000;
        bus.tlp_ready = 1'b1;
        issue_request(64'h0000_0001_2345_6000);
        n_checks++;
        if (bus.tlp_data !== 64'h010000FF_20000080 || bus.tlp_valid !== 1'b1 ||
            bus.tlp_upper_valid !== 1'b1 || bus.tlp_last !== 1'b0)
            $display("FAIL hdr64_word0 got %h v%b u%b l%b required 010000ff20000080 v1 u1 l0",
                     bus.tlp_data, bus.tlp_valid, bus.tlp_upper_valid, bus.tlp_last);
        else n_pass++;
        n_checks++;
        if (bus.rr_ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL hdr64_busy rr_ready %b busy %b required 0 1", bus.rr_ready, bus.busy);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.tlp_data !== 64'h23456000_00000001 || bus.tlp_valid !== 1'b1 ||
            bus.tlp_upper_valid !== 1'b1 || bus.tlp_last !== 1'b1)
            $display("FAIL hdr64_word1 got %h v%b u%b l%b required 2345600000000001 v1 u1 l1",
                     bus.tlp_data, bus.tlp_valid, bus.tlp_upper_valid, bus.tlp_last);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.tlp_valid !== 1'b0 || bus.rr_ready !== 1'b0)
            $display("FAIL hdr64_wait tlp_valid %b rr_ready %b required 0 0", bus.tlp_valid, bus.rr_ready);
        else n_pass++;
        clear_mon();
        send_words(64, base);
        n_checks++;
        if (bus.rc_last !== 1'b1 || bus.wvalid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL hdr64_done rc_last %b wvalid %b busy %b required 1 1 0",
                     bus.rc_last, bus.wvalid, bus.busy);
        else n_pass++;
        n_checks++;
        if (got_q.size() != 64 || got_q[63] !== base + 64'd63)
            $display("FAIL hdr64_words count %0d required 64", got_q.size());
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_hdr32_split();
        logic [63:0] base = 64'hA5A5_0000_0000_0000;
        int bad = 0;
        issue_request(64'h0000_0000_8000_0200);
        n_checks++;
        if (bus.tlp_data !== 64'h010000FF_00000080)
            $display("FAIL hdr32_word0 got %h required 010000ff00000080", bus.tlp_data);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.tlp_data !== 64'h00000000_80000200 || bus.tlp_upper_valid !== 1'b0 || bus.tlp_last !== 1'b1)
            $display("FAIL hdr32_word1 got %h u%b l%b required 0000000080000200 u0 l1",
                     bus.tlp_data, bus.tlp_upper_valid, bus.tlp_last);
        else n_pass++;
        @(negedge clock);
        clear_mon();
        send_words(16, base);
        repeat (20) @(negedge clock);
        bus.cpl_valid = 1'b1; bus.cpl_tag = 8'd5; bus.cpl_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clock);
        bus.cpl_valid = 1'b0; bus.cpl_tag = 8'd0;
        n_checks++;
        if (got_q.size() != 16 || n_rc != 0)
            $display("FAIL split_mid words %0d rc %0d required 16 0", got_q.size(), n_rc);
        else n_pass++;
        send_words(48, base + 64'd16);
        n_checks++;
        if (bus.rc_last !== 1'b1 || bus.wvalid !== 1'b1)
            $display("FAIL split_last rc_last %b wvalid %b required 1 1", bus.rc_last, bus.wvalid);
        else n_pass++;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== base + 64'(i)) bad++;
        n_checks++;
        if (got_q.size() != 64 || bad != 0 || n_rc != 1 || n_rc_wv != 1)
            $display("FAIL split_data words %0d bad %0d rc %0d rc_with_word %0d required 64 0 1 1",
                     got_q.size(), bad, n_rc, n_rc_wv);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.rr_ready !== 1'b1 || bus.rc_last !== 1'b0)
            $display("FAIL split_next rr_ready %b rc_last %b required 1 0", bus.rr_ready, bus.rc_last);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bus.tlp_ready = 1'b0;
        issue_request(64'h0000_0000_0004_0000);
        clear_mon();
        // Completion words outside WAIT must be dropped.
        bus.cpl_valid = 1'b1; bus.cpl_tag = 8'd0; bus.cpl_data = 64'h1111;
        for (int i = 0; i < 10; i++) begin
            if (bus.tlp_data !== 64'h010000FF_00000080 || bus.tlp_valid !== 1'b1 || bus.tlp_last !== 1'b0) bad++;
            @(negedge clock);
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold unstable cycles %0d required 0", bad);
        else n_pass++;
        bus.tlp_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.tlp_last !== 1'b1 || bus.tlp_data !== 64'h00000000_00040000)
            $display("FAIL bp_hdr1 got %h l%b required 0000000000040000 l1", bus.tlp_data, bus.tlp_last);
        else n_pass++;
        bus.cpl_valid = 1'b0;
        n_checks++;
        if (got_q.size() != 0) $display("FAIL bp_drop words %0d required 0", got_q.size());
        else n_pass++;
        do_reset();
    endtask

    task automatic test_timeout();
        int bad = 0;
        issue_request(64'h0000_0000_0010_0000);
        pass_header();
        clear_mon();
        send_words(10, 64'h7000);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (c < 100 && (bus.rc_last !== 1'b0 || bus.timeout !== 1'b0)) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL to_early early pulses %0d required 0", bad);
        else n_pass++;
        n_checks++;
        if (bus.rc_last !== 1'b1 || bus.timeout !== 1'b1 || bus.wvalid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL to_pulse rc_last %b timeout %b wvalid %b busy %b required 1 1 0 0",
                     bus.rc_last, bus.timeout, bus.wvalid, bus.busy);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.timeout !== 1'b0 || n_to != 1 || got_q.size() != 10)
            $display("FAIL to_single timeout %b pulses %0d words %0d required 0 1 10",
                     bus.timeout, n_to, got_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout_word_wins();
        issue_request(64'h0000_0000_0020_0000);
        pass_header();
        clear_mon();
        send_words(10, 64'h8000);
        repeat (99) @(negedge clock);
        send_words(1, 64'h800A);
        n_checks++;
        if (bus.wvalid !== 1'b1 || bus.timeout !== 1'b0 || bus.rc_last !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL win_edge wvalid %b timeout %b rc_last %b busy %b required 1 0 0 1",
                     bus.wvalid, bus.timeout, bus.rc_last, bus.busy);
        else n_pass++;
        send_words(53, 64'h800B);
        n_checks++;
        if (bus.rc_last !== 1'b1 || n_to != 0 || got_q.size() != 64 || got_q[63] !== 64'h803F)
            $display("FAIL win_done rc_last %b timeouts %0d words %0d required 1 0 64",
                     bus.rc_last, n_to, got_q.size());
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_reset_in_wait();
        logic [63:0] base = 64'hC000_0000_0000_0000;
        int bad = 0;
        issue_request(64'h0000_0000_0030_0000);
        pass_header();
        send_words(5, 64'h9000);
        clear_mon();
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({bus.tlp_valid, bus.wvalid, bus.rc_last, bus.timeout, bus.busy} !== 5'b0)
            $display("FAIL rst_wait_outputs got %b required 00000",
                     {bus.tlp_valid, bus.wvalid, bus.rc_last, bus.timeout, bus.busy});
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (n_rc != 0 || bus.rr_ready !== 1'b1)
            $display("FAIL rst_wait_norc rc %0d rr_ready %b required 0 1", n_rc, bus.rr_ready);
        else n_pass++;
        requester_id = 16'hABCD;
        issue_request(64'hFFFF_0000_0000_0E00);
        n_checks++;
        if (bus.tlp_data !== 64'hABCD00FF_20000080)
            $display("FAIL rst_new_word0 got %h required abcd00ff20000080", bus.tlp_data);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.tlp_data !== 64'h00000E00_FFFF0000 || bus.tlp_upper_valid !== 1'b1)
            $display("FAIL rst_new_word1 got %h u%b required 00000e00ffff0000 u1",
                     bus.tlp_data, bus.tlp_upper_valid);
        else n_pass++;
        @(negedge clock);
        clear_mon();
        send_words(64, base);
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== base + 64'(i)) bad++;
        n_checks++;
        if (bus.rc_last !== 1'b1 || got_q.size() != 64 || bad != 0 || n_rc != 1)
            $display("FAIL rst_new_done rc_last %b words %0d bad %0d rc %0d required 1 64 0 1",
                     bus.rc_last, got_q.size(), bad, n_rc);
        else n_pass++;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_hdr64();
        test_hdr32_split();
        test_backpressure();
        test_timeout();
        test_timeout_word_wins();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
